// File: rtl/logic_pkg.sv
// logic_pkg
//   Shared definitions for the 4-bit logic issue stage:
//   - opcode encodings for the NOT/AND/OR/XOR units
//   - the packed FIFO entry {op, a, b}
package logic_pkg;

  localparam int LOGIC_W = 4;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef struct packed {
    logic [1:0]         op;
    logic [LOGIC_W-1:0] a;
    logic [LOGIC_W-1:0] b;
  } entry_t;

endpackage

// File: rtl/logic_alu.sv
// logic_alu
//   Purely combinational bitwise ALU: op, a, b -> result (WIDTH bits,
//   no carry or extension). The NOT path is served by the logic_not unit.
//   Ports:
//     op_i     : opcode (OP_NOT/OP_AND/OP_OR/OP_XOR)
//     a_i      : operand A
//     b_i      : operand B (ignored for NOT)
//     result_o : bitwise result
module logic_alu
  import logic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] not_y;

  logic_not #(.WIDTH(WIDTH)) u_not (
    .a_i (a_i),
    .y_o (not_y)
  );

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_NOT:  result_o = not_y;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_not.sv
// logic_not
//   Bitwise inverter used as the NOT unit of the logic datapath.
//   Ports:
//     a_i : operand
//     y_o : ~a_i, same width
module logic_not #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = ~a_i;

endmodule

// File: rtl/logic_issue_stage.sv
// logic_issue_stage
//   Buffered issue stage for the bitwise logic units. Operations are
//   accepted into a DEPTH-entry FIFO, issued one per cycle through
//   logic_alu, and held in a result register until downstream takes them.
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     in_valid/in_ready     : upstream handshake
//     in_op, in_a, in_b     : operation and operands
//     out_valid/out_ready   : downstream handshake
//     out_op, out_result    : held opcode and result
//     busy                  : FIFO or result register occupied
module logic_issue_stage
  import logic_pkg::*;
#(
  parameter int WIDTH = LOGIC_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_op,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // FIFO storage carries data only; it needs no reset because the
  // count decides which entries are meaningful.
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_op_q, out_op_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;

  logic               push, pop;
  entry_t             head;
  logic [WIDTH-1:0]   alu_result;

  // Ready depends only on registered count, so out_ready never reaches it.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0) && (!out_valid_q || out_ready);
  assign head     = mem_q[rd_ptr_q];

  logic_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i     (head.op),
    .a_i      (head.a),
    .b_i      (head.b),
    .result_o (alu_result)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_result_d = out_result_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      out_valid_d  = 1'b1;
      out_op_d     = head.op;
      out_result_d = alu_result;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q].op <= in_op;
      mem_q[wr_ptr_q].a  <= in_a;
      mem_q[wr_ptr_q].b  <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_result_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_result_q <= out_result_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_result = out_result_q;
  assign busy       = (count_q != '0) || out_valid_q;

endmodule
